// File: rtl/logic_unit_seq.sv
// logic_unit_seq: registered bitwise logic unit with an optional accumulate
// mode. Operand sets enter on a valid/ready handshake and results leave
// through a one-entry output register that honours backpressure.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The producer holds valid and its payload stable until the transfer
// happens. Ready may depend combinationally on the consumer's ready. Here,
// in_ready = !out_valid || out_ready, so the block runs at full throughput
// while the consumer keeps out_ready high.
module logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] result;
  logic             accept;

  // One-entry register: space is available when empty or when it is being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the same cycle as an accept makes the operation see an empty accumulator.
  assign acc_eff = acc_clr ? '0 : acc;
  assign bx      = acc_en ? acc_eff : b;

  // Select the logic function applied to a and the effective operand b.
  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = a & bx;
      OP_OR:   result = a | bx;
      OP_NOTA: result = ~a;
      OP_NAND: result = ~(a & bx);
      OP_NOR:  result = ~(a | bx);
      OP_XOR:  result = a ^ bx;
      OP_XNOR: result = ~(a ^ bx);
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  // Output register, flags, accumulator and transaction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      zero      <= 1'b1;
      ones      <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else if (accept) begin
      y         <= result;
      zero      <= (result == '0);
      ones      <= (&result);
      out_valid <= 1'b1;
      acc       <= result;
      op_count  <= op_count + 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc_clr) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Registered, parametrised bitwise logic unit: applies one of eight logic operations to two WIDTH-bit operands, with an optional accumulate mode that substitutes the previous result for operand b. Inputs arrive on a valid/ready handshake and results leave through a one-entry output register with backpressure. It sits between an operand source and any downstream consumer, and generalises the single-bit AND/OR/NOT gate block to vectors, more operations and pipelined flow control.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 8, width of the accepted-transaction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept an operand set this cycle
- op  input  3  operation select (see Operation)
- acc_en  input  1  1: operand b replaced by accumulator
- acc_clr  input  1  synchronous accumulator clear
- a  input  WIDTH  operand a
- b  input  WIDTH  operand b (ignored when acc_en=1)
- out_valid  output  1  y/zero/ones valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  registered result
- zero  output  1  registered flag, y == 0
- ones  output  1  registered flag, y == all ones
- op_count  output  CNT_W  number of accepted operand sets, wraps modulo 2^CNT_W

## Operation
- op encoding: 000 a&b, 001 a|b, 010 ~a, 011 ~(a&b), 100 ~(a|b), 101 a^b, 110 ~(a^b), 111 a (pass).
- Effective operand: bx = acc_en ? acc : b. Unary ops (010, 111) ignore bx.
- Accept: in_valid && in_ready. On accept: y ← f(op, a, bx), zero/ones computed from the new y, out_valid ← 1, acc ← new result, op_count ← op_count + 1 (wraps).
- in_ready = !out_valid || out_ready (combinational; one-entry register, full throughput).
- out_valid && out_ready with no accept in the same cycle: out_valid ← 0; y/flags keep their last value.
- out_valid && !out_ready: y, zero, ones and out_valid are held stable; no accept possible.
- Simultaneous drain and accept: the new result replaces the old one, out_valid stays 1.
- acc_clr without accept: acc ← 0.
- acc_clr with accept: the operation uses bx = 0 when acc_en=1; acc ← new result (accept wins for the acc write).
- acc is internal; it changes only on accept or acc_clr.
- Input changes while !in_ready have no effect.

## Timing
- Reset (rst_n low, asynchronous): y=0, zero=1, ones=0, out_valid=0, acc=0, op_count=0. in_ready=1 after reset.
- Latency: result visible on y with out_valid=1 on the clock edge that accepts the operands (one cycle from the input presented).
- Throughput: one operation per cycle while out_ready=1.
- Reset asserted mid-transaction: the pending result is discarded and all state returns to reset values immediately. No acceptance while rst_n=0.
- WIDTH=1: zero = ~y, ones = y.
- op_count wraps from 2^CNT_W−1 to 0 without any flag.

## Test plan
- Reset/idle: assert rst_n=0 mid-stream with out_valid=1 → y=0, zero=1, out_valid=0, op_count=0 asynchronously; in_ready=1 after release.
- All ops, WIDTH=8: a=8'hCA, b=8'h5F, op 0..7 with out_ready=1 → y = 4A, DF, 35, B5, 20, 95, 6A, CA on consecutive cycles, op_count=8, and each flag low.
- Backpressure: out_ready=0 after the first result (op=000, a=FF, b=0F, y=0F) → in_ready=0, y holds 0F for 5 cycles, and a second operand set presented meanwhile is not taken; out_ready=1 → the second operand set is accepted on that cycle.
- Accumulate: acc_clr pulse, then acc_en=1, op=001 with a=01, 02, 04, 80 → y=01, 03, 07, 87; then op=101 with a=87 → y=00, zero=1.
- Clear/accept collision: acc=FF, acc_clr=1 and accept with acc_en=1, op=001, a=10 → y=10 (acc treated as 0), acc=10 afterwards. Flags: a=FF, op=111 → ones=1.
- Counter wrap: CNT_W=4, 17 accepts → op_count=1.
